apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 6 +
 rtl/apb_master_timeout.sv | 16 +
 rtl/apb_master.sv | 74 +++++++
 tb/tb_apb_master.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: FSM state encoding and default bus widths shared by apb_master and apb_slave.
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 8;
endpackage

// File: rtl/apb_master_timeout.sv
// apb_master_timeout: counts consecutive ACCESS wait cycles and flags the one that hits the limit.
module apb_master_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic wait_cycle,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] count;
  assign expired = wait_cycle && (count == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) count <= '0;
    else count <= (wait_cycle && !expired) ? count + 1'b1 : '0;
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master bridging a valid/ready command port to APB.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDRESSWIDTH   = APB_ADDR_W,
  parameter int DATAWIDTH      = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESSWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0]    cmd_wdata,
  output logic                    rsp_valid,
  output logic [DATAWIDTH-1:0]    rsp_rdata,
  output logic                    rsp_timeout,
  output logic [ADDRESSWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0]    PWDATA,
  output logic                    PWRITE,
  output logic                    PSELx,
  output logic                    PENABLE,
  input  logic [DATAWIDTH-1:0]    PRDATA,
  input  logic                    PREADY
);
  apb_state_e state, state_nx;
  logic done, hs, abort;
  assign done      = (state == ACCESS) && PREADY;
  assign cmd_ready = PRESETn && ((state == IDLE) || done);
  assign hs        = cmd_valid && cmd_ready;
  assign PSELx     = state != IDLE;
  assign PENABLE   = state == ACCESS;
  // A command can only be taken in IDLE or a completing ACCESS, so hs wins over every other transition.
  always_comb
    state_nx = hs ? SETUP :
               (state == SETUP) ? ACCESS :
               (state == ACCESS && !done && !abort) ? ACCESS : IDLE;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state     <= IDLE;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nx;
      rsp_valid <= done || abort;
      if (hs) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end
      if (done && !PWRITE) rsp_rdata <= PRDATA;
    end
`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .wait_cycle ((state == ACCESS) && !PREADY),
    .expired    (abort)
  );
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) rsp_timeout <= 1'b0;
    else rsp_timeout <= abort;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized scoreboard bench for apb_master with a memory-backed APB slave model.
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 8;
  logic PCLK = 0, PRESETn = 0, cmd_valid = 0, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_timeout, PWRITE, PSELx, PENABLE;
  logic [DW-1:0] rsp_rdata, PWDATA;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PRDATA = '0;
  logic PREADY = 0;
  int vectors = 0, errors = 0, cyc = 0;
  typedef struct {logic [DW-1:0] rdata; logic to;} exp_t;
  exp_t sb[$];
  int rsp_cyc[$];
  logic [DW-1:0] mem [256];
  logic [DW-1:0] smem [256];
  logic [DW-1:0] last_rd = '0;
  int wait_mode = 0;
  logic p_sel = 0, p_en = 0, p_write = 0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;

  apb_master dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSELx(PSELx), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Slave: wait_mode >=0 fixed wait states, -1 random 0..3, -2 never ready. PREADY is junk outside ACCESS.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge PCLK);
      if (PSELx && PENABLE) begin
        if (wcnt == 0) begin
          PREADY = 1;
          PRDATA = smem[PADDR[7:0]];
          if (PWRITE) smem[PADDR[7:0]] = PWDATA;
        end else begin
          PREADY = 0;
          PRDATA = DW'($urandom);
          wcnt--;
        end
      end else begin
        PREADY = 1'($urandom);
        PRDATA = DW'($urandom);
        wcnt = wait_mode == -2 ? (1 << 30) : wait_mode < 0 ? int'($urandom_range(0, 3)) : wait_mode;
      end
    end
  end

  // Response monitor: every rsp_valid pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (rsp_valid) begin
        rsp_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_timeout", rsp_timeout, e.to);
        end
      end
    end
  end

  // Protocol monitor: SETUP lasts one cycle, PENABLE implies PSELx, request fields stable.
  initial forever begin
    @(negedge PCLK);
    if (PRESETn) begin
      if (PENABLE) check("penable_needs_psel", PSELx, 1);
      if (PENABLE && p_sel) begin
        check("paddr_stable", PADDR, p_addr);
        check("pwdata_stable", PWDATA, p_wdata);
        check("pwrite_stable", PWRITE, p_write);
      end
      if (p_sel && !p_en) check("setup_one_cycle", PENABLE, 1);
    end
    p_sel = PSELx; p_en = PENABLE; p_addr = PADDR; p_wdata = PWDATA; p_write = PWRITE;
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic to, output int hs);
    bit ok;
    ok = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge PCLK); #1;
      ok = cmd_ready;
      @(posedge PCLK); #1;
    end
    cmd_valid = 0;
    hs = cyc;
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL handshake: got no cmd_ready expected acceptance within 200 cycles");
    end else begin
      if (!to) begin
        if (w) mem[a[7:0]] = d;
        else last_rd = mem[a[7:0]];
      end
      sb.push_back('{last_rd, to});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge PCLK);
    if (sb.size() > 0) begin
      vectors++;
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
    @(negedge PCLK);
  endtask

  initial begin
    int hs1, hs2, n, nrv;
    logic [AW-1:0] a;
    for (int i = 0; i < 256; i++) begin
      mem[i] = DW'($urandom);
      smem[i] = mem[i];
    end
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_psel", PSELx, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    @(posedge PCLK); #1 PRESETn = 1;
    @(negedge PCLK);
    check("ready_after_reset", cmd_ready, 1);

    @(posedge PCLK); #1;
    issue(1, 32'h1AA, 8'hF0, 0, hs1);
    @(negedge PCLK);
    check("wr_setup_psel", PSELx, 1);
    check("wr_setup_penable", PENABLE, 0);
    check("wr_paddr", PADDR, 32'h1AA);
    check("wr_pwdata", PWDATA, 8'hF0);
    check("wr_pwrite", PWRITE, 1);
    @(negedge PCLK);
    check("wr_access_penable", PENABLE, 1);
    @(negedge PCLK);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_done_psel", PSELx, 0);

    wait_mode = 3;
    @(posedge PCLK); #1;
    issue(0, 32'h1AA, 8'h00, 0, hs1);
    n = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(negedge PCLK);
      if (PENABLE) n++;
    end
    check("rd_penable_cycles", n, 4);
    check("rd_rdata", rsp_rdata, 8'hF0);

    wait_mode = 0;
    drain();
    @(posedge PCLK); #1;
    rsp_cyc.delete();
    issue(1, 32'h10, 8'hAA, 0, hs1);
    issue(1, 32'h14, 8'h55, 0, hs2);
    check("b2b_handshake_gap", hs2 - hs1, 2);
    drain();
    check("b2b_rsp_count", rsp_cyc.size(), 2);
    if (rsp_cyc.size() == 2) check("b2b_rsp_gap", rsp_cyc[1] - rsp_cyc[0], 2);

    wait_mode = -2;
    @(posedge PCLK); #1;
`ifdef APB_MASTER_TIMEOUT_EN
    issue(1, 32'h2F0, 8'h3C, 1, hs1);
    drain();
    check("timeout_idle", PSELx, 0);
    @(posedge PCLK); #1;
    issue(1, 32'h3F0, 8'h3C, 0, hs1);
    repeat (3) @(negedge PCLK);
`else
    issue(1, 32'h2F0, 8'h3C, 0, hs1);
    nrv = 0;
    repeat (100) begin
      @(negedge PCLK);
      if (rsp_valid || rsp_timeout) nrv++;
    end
    check("hang_no_rsp", nrv, 0);
    check("hang_in_access", PENABLE, 1);
`endif
    check("pre_reset_access", PENABLE, 1);
    #2 PRESETn = 0;
    #1;
    check("async_rst_psel", PSELx, 0);
    check("async_rst_penable", PENABLE, 0);
    check("async_rst_ready", cmd_ready, 0);
    check("async_rst_paddr", PADDR, 0);
    sb.delete();
    last_rd = '0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1;
    @(negedge PCLK);
    check("ready_after_rerelease", cmd_ready, 1);
    check("rdata_cleared", rsp_rdata, 0);

    wait_mode = -1;
    @(posedge PCLK); #1;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge PCLK); #1; end
      a = $urandom;
      a[7:4] = '0;
      issue(1'($urandom), a, DW'($urandom), 0, hs1);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
